// File: rtl/mmio_bus_decoder_if.sv
// Bus bundle for mmio_bus_decoder: CPU request/response plus the shared slave-side signals.
// The decoder connects through the "slave" modport; the CPU and slave devices use "master".
interface mmio_bus_decoder_if #(
  parameter int unsigned NSLV = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);
  logic               cpu_req;
  logic               cpu_we;
  logic [AW-1:0]      cpu_addr;
  logic [DW-1:0]      cpu_wdata;
  logic [DW-1:0]      cpu_rdata;
  logic               cpu_ready;
  logic               cpu_err;
  logic [NSLV-1:0]    s_sel;
  logic               s_we;
  logic [AW-1:0]      s_addr;
  logic [DW-1:0]      s_wdata;
  logic [NSLV*DW-1:0] s_rdata;
  logic [NSLV-1:0]    s_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata, s_ready,
    output cpu_rdata, cpu_ready, cpu_err, s_sel, s_we, s_addr, s_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata, s_ready,
    input  cpu_rdata, cpu_ready, cpu_err, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmio_bus_decoder.sv
// Single-master MMIO address decoder: routes one CPU access at a time to NSLV fixed-size windows.
// Optional access watchdog enabled by defining MMIO_BUS_TIMEOUT_EN.
module mmio_bus_decoder #(
  parameter int unsigned        NSLV        = 4,
  parameter int unsigned        AW          = 32,
  parameter int unsigned        DW          = 32,
  parameter int unsigned        REGION_LOG2 = 10,
  parameter logic [NSLV*AW-1:0] BASES       = {32'h00000C00, 32'h00000800, 32'h00000400, 32'h00000000},
  parameter int unsigned        TMO_CYCLES  = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mmio_bus_decoder_if.slave bus_io
);

  localparam int unsigned TAG_W = AW - REGION_LOG2;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
`ifdef MMIO_BUS_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  // No watchdog in this build; the limit parameter is accepted but has no effect.
  logic unused_tmo_c;
  assign unused_tmo_c = ^TMO_W'(TMO_CYCLES);
`endif

  logic            hit_c;
  logic [NSLV-1:0] hit_sel_c;
  logic [DW-1:0]   slv_rdata_c;
  logic            slv_ready_c;

  // Window match on the address tag; first (lowest-index) hit wins on overlap.
  always_comb begin
    hit_c     = 1'b0;
    hit_sel_c = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!hit_c && (bus_io.cpu_addr[AW-1:REGION_LOG2] == BASES[i*AW+REGION_LOG2 +: TAG_W])) begin
        hit_c        = 1'b1;
        hit_sel_c[i] = 1'b1;
      end
    end
  end

  // Only the selected slave's data and ready are observed.
  always_comb begin
    slv_rdata_c = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (sel_q[i]) slv_rdata_c = bus_io.s_rdata[i*DW +: DW];
    end
  end

  assign slv_ready_c = |(bus_io.s_ready & sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = err_q;
`ifdef MMIO_BUS_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus_io.cpu_req) begin
          if (hit_c) begin
            sel_d   = hit_sel_c;
            we_d    = bus_io.cpu_we;
            addr_d  = bus_io.cpu_addr;
            wdata_d = bus_io.cpu_wdata;
`ifdef MMIO_BUS_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            ready_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (slv_ready_c) begin
          rdata_d = we_q ? '0 : slv_rdata_c;
          sel_d   = '0;
          ready_d = 1'b1;
          state_d = RESP;
        end
`ifdef MMIO_BUS_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
          tmo_d   = tmo_q + TMO_W'(1);
          err_d   = 1'b1;
          rdata_d = '0;
          sel_d   = '0;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
`endif
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MMIO_BUS_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef MMIO_BUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus_io.s_sel     = sel_q;
  assign bus_io.s_we      = we_q;
  assign bus_io.s_addr    = addr_q;
  assign bus_io.s_wdata   = wdata_q;
  assign bus_io.cpu_rdata = rdata_q;
  assign bus_io.cpu_ready = ready_q;
  assign bus_io.cpu_err   = err_q;

endmodule

// File: doc/mmio_bus_decoder.md
MMIO_BUS_DECODER -- requirements
Module: mmio_bus_decoder

Interface
REQ-001 Parameter NSLV, default 4: number of slave channels (1..8).
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter REGION_LOG2, default 10: log2 of every slave region size in bytes (1024-byte windows).
REQ-005 Parameter BASES, default {32'h00000C00, 32'h00000800, 32'h00000400, 32'h00000000}: NSLV*AW packed base addresses, slave 0 in the LSBs; each base aligned to 2^REGION_LOG2.
REQ-006 Parameter TMO_CYCLES, default 15: wait-state limit in clocks (1..255).
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 cpu_req  in  1  request strobe, sampled only in IDLE.
REQ-010 cpu_we  in  1  1 = write, 0 = read.
REQ-011 cpu_addr  in  AW  byte address.
REQ-012 cpu_wdata  in  DW  write data.
REQ-013 cpu_rdata  out  DW  read data, valid while cpu_ready is high.
REQ-014 cpu_ready  out  1  one-cycle completion pulse.
REQ-015 cpu_err  out  1  error qualifier, valid with cpu_ready.
REQ-016 s_sel  out  NSLV  one-hot slave select, registered.
REQ-017 s_we, s_addr[AW], s_wdata[DW]  out  latched request fields, shared by all slaves.
REQ-018 s_rdata  in  NSLV*DW  packed slave read data.
REQ-019 s_ready  in  NSLV  per-slave completion, sampled only for the selected slave.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 Decode: slave i matches when cpu_addr[AW-1:REGION_LOG2] == BASES_i[AW-1:REGION_LOG2]; on overlap, lowest index wins.
REQ-022 IDLE with cpu_req=1 and a match: latch cpu_we, cpu_addr and cpu_wdata into s_we, s_addr and s_wdata; set s_sel one-hot; go to ACCESS.
REQ-023 IDLE with cpu_req=1 and no match: s_sel stays 0; set the error flag; go to RESP.
REQ-024 ACCESS: when s_ready of the selected slave is 1, capture its s_rdata (capture zero on writes), clear s_sel, go to RESP.
REQ-025 RESP: cpu_ready=1 for exactly one cycle, with cpu_err equal to the error flag; then go to IDLE and clear the error flag.
REQ-026 Latency: request sampled at edge T gives s_sel high after T; zero-wait slave gives cpu_ready in cycle T+2; unmapped address gives cpu_ready in cycle T+1.
REQ-027 cpu_req is ignored in ACCESS and RESP; a new request may be sampled in the first IDLE cycle after RESP.
REQ-028 s_ready of unselected slaves, and any s_ready outside ACCESS, is ignored.
REQ-029 cpu_rdata holds its last captured value outside RESP; it is 0 on error responses.

Reset
REQ-030 On reset: state=IDLE, s_sel=0, s_we=0, s_addr=0, s_wdata=0, cpu_rdata=0, cpu_ready=0, cpu_err=0, timeout counter=0.
REQ-031 Reset in any state aborts the transfer in the same edge; no cpu_ready pulse is issued for the aborted transfer.

Configuration
REQ-032 Macro MMIO_BUS_TIMEOUT_EN defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without s_ready; when it reaches TMO_CYCLES with s_ready still 0, go to RESP with error, cpu_rdata=0, and s_sel cleared.
REQ-033 Macro MMIO_BUS_TIMEOUT_EN undefined: no counter is built; ACCESS waits indefinitely for s_ready.
REQ-034 If s_ready and timeout coincide in the same cycle, s_ready wins with no error.

Verification
REQ-035 Read at 0x404, slave 1 with s_ready tied to 1 and s_rdata[1]=0x12345678 -> s_sel=0010 for one cycle; cpu_ready at T+2 with cpu_rdata=0x12345678 and cpu_err=0.
REQ-036 Write 0xA5A5A5A5 to 0x008, slave 0 asserting s_ready after 3 wait cycles -> s_sel=0001 held 4 cycles, s_wdata=0xA5A5A5A5, s_we=1; cpu_ready with cpu_err=0.
REQ-037 Read at 0x00001000 (unmapped) -> s_sel stays 0; cpu_ready at T+1 with cpu_err=1 and cpu_rdata=0.
REQ-038 With MMIO_BUS_TIMEOUT_EN, read at 0xC00 with s_ready[3]=0 -> cpu_ready with cpu_err=1 after 15 ACCESS cycles; without the macro -> no cpu_ready after 100 cycles.
REQ-039 Assert reset during ACCESS, then a new read at 0x800 -> no stale cpu_ready; the new transfer completes normally on slave 2.
REQ-040 Hold cpu_req=1 continuously -> back-to-back transfers, each separated by one IDLE cycle, with exactly one cpu_ready per transfer.
